// File: rtl/parity_pop_scheduler_pkg.sv
// parity_pop_scheduler_pkg: shared types and the parity helper for the pop scheduler.
`default_nettype none

package parity_pop_scheduler_pkg;

  typedef enum logic [0:0] {EVEN = 1'b0, ODD = 1'b1} parity_mode_e;
  typedef enum logic [0:0] {MSB = 1'b0, LSB = 1'b1} parity_pos_e;
  typedef enum logic [0:0] {S_EMPTY = 1'b0, S_FULL = 1'b1} sched_state_e;

  // Callers zero-extend their word to this width; padding zeros leave the XOR unchanged.
  localparam int PARITY_MAX_W = 64;

  function automatic logic parity_ok(input logic [PARITY_MAX_W-1:0] word,
                                     input parity_mode_e mode);
    return (^word) == (mode == ODD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/parity_pop_scheduler_rr_picker.sv
// rr_picker: combinational round-robin search for the first set request at or after ptr.
`default_nettype none

module rr_picker #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (req[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/parity_pop_scheduler.sv
// parity_pop_scheduler: round-robin pops FIFO heads, drops bad-parity words with
// per-source error counts, and registers good payloads for the consumer.
`default_nettype none

module parity_pop_scheduler
  import parity_pop_scheduler_pkg::*;
#(
  parameter int           NUM_SRC           = 4,
  parameter int           DATA_WIDTH        = 8,
  parameter parity_mode_e PARITY_MODE       = EVEN,
  parameter parity_pos_e  PARITY_BIT_CHOICE = MSB,
  parameter int           ERR_CNT_WIDTH     = 16,
  localparam int          IDX_W             = $clog2(NUM_SRC)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_SRC-1:0]               pop_valid_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]    pop_data_i,
  output logic [NUM_SRC-1:0]               pop_grant_o,
  output logic                             valid_o,
  output logic [DATA_WIDTH-2:0]            data_o,
  output logic [IDX_W-1:0]                 src_o,
  input  logic                             grant_i,
  input  logic                             err_clr_i,
  output logic [NUM_SRC*ERR_CNT_WIDTH-1:0] err_cnt_o
);

  sched_state_e             r_state;
  logic [DATA_WIDTH-2:0]    r_data;
  logic [IDX_W-1:0]         r_src;
  logic [IDX_W-1:0]         r_ptr;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt [NUM_SRC];

  logic                     w_found;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_slot_free;
  logic                     w_take;
  logic                     w_good;
  logic                     w_drop;
  logic [DATA_WIDTH-1:0]    w_head;
  logic [DATA_WIDTH-2:0]    w_payload;
  logic [IDX_W-1:0]         w_ptr_next;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req   (pop_valid_i),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_slot_free = (r_state == S_EMPTY) || grant_i;
  assign w_take      = rst_ni && w_slot_free && w_found;
  assign w_head      = pop_data_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_good      = parity_ok(PARITY_MAX_W'(w_head), PARITY_MODE);
  assign w_drop      = w_take && !w_good;
  assign w_payload   = (PARITY_BIT_CHOICE == MSB) ? w_head[DATA_WIDTH-2:0]
                                                  : w_head[DATA_WIDTH-1:1];
  assign w_ptr_next  = (w_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_idx + IDX_W'(1);

  always_comb begin
    pop_grant_o        = '0;
    pop_grant_o[w_idx] = w_take;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_EMPTY;
      r_data  <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else if (w_take) begin
      r_ptr <= w_ptr_next;
      if (w_good) begin
        r_state <= S_FULL;
        r_data  <= w_payload;
        r_src   <= w_idx;
      end else begin
        r_state <= S_EMPTY;
      end
    end else if (w_slot_free) begin
      r_state <= S_EMPTY;
    end
  end

  // Clear wins over a same-cycle drop; counters stick at all-ones.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!rst_ni || err_clr_i) begin
        r_err_cnt[k] <= '0;
      end else if (w_drop && (w_idx == IDX_W'(k)) && !(&r_err_cnt[k])) begin
        r_err_cnt[k] <= r_err_cnt[k] + ERR_CNT_WIDTH'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_err_out
    assign err_cnt_o[k*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = r_err_cnt[k];
  end

  assign valid_o = (r_state == S_FULL);
  assign data_o  = r_data;
  assign src_o   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_parity_pop_scheduler.sv
// tb_parity_pop_scheduler: directed vectors for the default build plus a 2-bit-counter build.
`default_nettype none

module tb_parity_pop_scheduler;

  logic        clk_i;
  logic        rst_ni;
  logic [3:0]  pop_valid_i;
  logic [31:0] pop_data_i;
  logic        grant_i;
  logic        err_clr_i;

  logic [3:0]  pop_grant_o;
  logic        valid_o;
  logic [6:0]  data_o;
  logic [1:0]  src_o;
  logic [63:0] err_cnt_o;

  logic [3:0]  s_pop_grant_o;
  logic        s_valid_o;
  logic [6:0]  s_data_o;
  logic [1:0]  s_src_o;
  logic [7:0]  s_err_cnt_o;

  int n_cmp;
  int n_err;

  parity_pop_scheduler u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .pop_valid_i (pop_valid_i),
    .pop_data_i  (pop_data_i),
    .pop_grant_o (pop_grant_o),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .src_o       (src_o),
    .grant_i     (grant_i),
    .err_clr_i   (err_clr_i),
    .err_cnt_o   (err_cnt_o)
  );

  parity_pop_scheduler #(.ERR_CNT_WIDTH(2)) u_dut_sat (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .pop_valid_i (pop_valid_i),
    .pop_data_i  (pop_data_i),
    .pop_grant_o (s_pop_grant_o),
    .valid_o     (s_valid_o),
    .data_o      (s_data_o),
    .src_o       (s_src_o),
    .grant_i     (grant_i),
    .err_clr_i   (err_clr_i),
    .err_cnt_o   (s_err_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [7:0] w);
    pop_data_i[k*8 +: 8] = w;
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst_ni      = 1'b0;
    pop_valid_i = 4'hF;
    pop_data_i  = '0;
    grant_i     = 1'b1;
    err_clr_i   = 1'b0;

    // Reset held for three cycles with every source requesting.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i); #1;
      chk("rst_pop_grant", 64'(pop_grant_o), 64'h0);
      chk("rst_valid", 64'(valid_o), 64'h0);
      chk("rst_err_cnt", err_cnt_o, 64'h0);
      chk("rst_err_cnt_sat", 64'(s_err_cnt_o), 64'h0);
    end

    // Good word 0x81 from src2 with consumer stalled.
    @(negedge clk_i);
    rst_ni      = 1'b1;
    grant_i     = 1'b0;
    pop_valid_i = 4'b0100;
    set_word(2, 8'h81);
    #1 chk("src2_pop_grant", 64'(pop_grant_o), 64'h4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i); #1;
      chk("hold_valid", 64'(valid_o), 64'h1);
      chk("hold_data", 64'(data_o), 64'h01);
      chk("hold_src", 64'(src_o), 64'h2);
      chk("hold_pop_grant", 64'(pop_grant_o), 64'h0);
    end

    // Consume with nothing waiting: slot empties.
    @(negedge clk_i);
    grant_i     = 1'b1;
    pop_valid_i = 4'b0000;
    #1 chk("drain_pop_grant", 64'(pop_grant_o), 64'h0);

    // Bad 0x01 from src1 is dropped and counted; pointer is 3 here.
    @(negedge clk_i);
    grant_i     = 1'b0;
    pop_valid_i = 4'b0010;
    set_word(1, 8'h01);
    #1;
    chk("drained_valid", 64'(valid_o), 64'h0);
    chk("bad_pop_grant", 64'(pop_grant_o), 64'h2);
    @(negedge clk_i);
    set_word(1, 8'h03);
    #1;
    chk("bad_valid", 64'(valid_o), 64'h0);
    chk("bad_err_cnt", err_cnt_o, 64'h0000_0000_0001_0000);
    chk("bad_err_cnt_sat", 64'(s_err_cnt_o), 64'h04);
    chk("good1_pop_grant", 64'(pop_grant_o), 64'h2);
    @(negedge clk_i); #1;
    chk("good1_valid", 64'(valid_o), 64'h1);
    chk("good1_data", 64'(data_o), 64'h03);
    chk("good1_src", 64'(src_o), 64'h1);

    // Serve src3 so the pointer wraps to 0 before the streaming run.
    grant_i     = 1'b1;
    pop_valid_i = 4'b1000;
    set_word(3, 8'h33);
    #1 chk("wrap_pop_grant", 64'(pop_grant_o), 64'h8);

    // Streaming with all sources valid: 0,1,2,3,0 back to back.
    @(negedge clk_i);
    pop_valid_i = 4'hF;
    pop_data_i  = 32'h3322_1100;
    #1 chk("rr_pop_grant_first", 64'(pop_grant_o), 64'h1);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] exp_data;
      exp_data = 8'h11 * 8'(i % 4);
      @(negedge clk_i); #1;
      chk("rr_valid", 64'(valid_o), 64'h1);
      chk("rr_src", 64'(src_o), 64'(i % 4));
      chk("rr_data", 64'(data_o), 64'(exp_data[6:0]));
      chk("rr_pop_grant", 64'(pop_grant_o), 64'(4'b0001 << ((i + 1) % 4)));
    end

    // Reset while FULL discards the word and returns the pointer to 0.
    @(negedge clk_i);
    rst_ni      = 1'b0;
    grant_i     = 1'b0;
    pop_valid_i = 4'b0000;
    #1 chk("midrst_pop_grant", 64'(pop_grant_o), 64'h0);
    @(negedge clk_i);
    #1;
    chk("midrst_valid", 64'(valid_o), 64'h0);
    chk("midrst_data", 64'(data_o), 64'h0);
    chk("midrst_src", 64'(src_o), 64'h0);
    rst_ni      = 1'b1;
    pop_valid_i = 4'b1001;
    pop_data_i  = 32'h3300_0000;
    #1 chk("postrst_pop_grant", 64'(pop_grant_o), 64'h1);
    @(negedge clk_i); #1;
    chk("postrst_valid", 64'(valid_o), 64'h1);
    chk("postrst_src", 64'(src_o), 64'h0);

    // Five bad words from src0: 2-bit counter saturates at 3, 16-bit reaches 5.
    grant_i     = 1'b1;
    pop_valid_i = 4'b0001;
    pop_data_i  = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      #1 chk("sat_pop_grant", 64'(pop_grant_o), 64'h1);
      @(negedge clk_i); #1;
      chk("sat_valid", 64'(valid_o), 64'h0);
      chk("sat_err_cnt", err_cnt_o, 64'(i + 1));
      chk("sat_err_cnt_sat", 64'(s_err_cnt_o), 64'((i + 1 > 3) ? 3 : i + 1));
    end

    // Clear coincident with a sixth bad word leaves zero.
    err_clr_i = 1'b1;
    #1 chk("clr_pop_grant", 64'(pop_grant_o), 64'h1);
    @(negedge clk_i);
    err_clr_i   = 1'b0;
    pop_valid_i = 4'b0000;
    #1;
    chk("clr_err_cnt", err_cnt_o, 64'h0);
    chk("clr_err_cnt_sat", 64'(s_err_cnt_o), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/parity_pop_scheduler.md
Name: parity_pop_scheduler

Overview:
- Shares one parity-check/output stage between NUM_SRC FIFOs using round-robin arbitration.
- Each cycle with a free output slot, it selects one FIFO head and checks its parity:
  - Bad words are popped and dropped, and the source's error counter is incremented.
  - Good words are popped, stripped of the parity bit and registered for the top level.
- Sits between the RX FIFO bank and the top-level consumer.

Parameters:
- NUM_SRC, 4: number of source FIFOs (≥2).
- DATA_WIDTH, 8: FIFO word width including parity bit (≥2).
- PARITY_MODE, EVEN: EVEN(0)/ODD(1); a word is good iff XOR of all DATA_WIDTH bits == PARITY_MODE.
- PARITY_BIT_CHOICE, MSB: MSB or LSB; position of the parity bit, removed from data_o.
- ERR_CNT_WIDTH, 16: width of each per-source error counter.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  synchronous reset, active low
- pop_valid_i  in  NUM_SRC  bit k=1: FIFO k presents a word
- pop_data_i  in  NUM_SRC*DATA_WIDTH  FIFO k word in slice [k*DATA_WIDTH +: DATA_WIDTH]
- pop_grant_o  out  NUM_SRC  one-hot-or-zero; bit k pops FIFO k this cycle
- valid_o  out  1  output register holds a good word
- data_o  out  DATA_WIDTH-1  payload with parity bit removed
- src_o  out  $clog2(NUM_SRC)  index of source that supplied data_o
- grant_i  in  1  top level consumes data_o this cycle
- err_clr_i  in  1  clear all error counters
- err_cnt_o  out  NUM_SRC*ERR_CNT_WIDTH  saturating bad-word count per source, slice k

Behaviour:
- Reset (rst_ni=0 at edge):
  - valid_o=0, data_o=0, src_o=0.
  - RR pointer=0, all err counters=0.
  - pop_grant_o forced 0 while rst_ni=0.
- State machine with two states, EMPTY (valid_o=0) and FULL (valid_o=1).
- Slot free is defined as: state==EMPTY, or (state==FULL and grant_i=1).
- Selection:
  - Applies only when the slot is free.
  - Candidate = first k with pop_valid_i[k]=1, searching cyclically from the RR pointer.
  - No candidate: pop_grant_o=0.
- Candidate good:
  - pop_grant_o[k]=1 (combinational, same cycle).
  - Next edge: data_o=payload, src_o=k, state=FULL.
  - Pointer=(k+1) mod NUM_SRC.
- Candidate bad:
  - pop_grant_o[k]=1, err_cnt[k]+=1 (saturating at all-ones).
  - Pointer=(k+1) mod NUM_SRC.
  - Next state is EMPTY, including when a consumed FULL word leaves the slot.
- FULL with grant_i=0: data_o/src_o stable, pop_grant_o=0, no drops.
- FULL with grant_i=1 and no candidate: next state EMPTY.
- Throughput: one word per cycle when grant_i is held high; latency from pop to valid_o is 1 cycle.
- Only one source is examined per cycle. A bad word costs one cycle.
- grant_i while EMPTY is ignored.
- err_clr_i has priority over an increment in the same cycle; the counter ends at 0.
- Payload extraction:
  - MSB: data_o = word[DATA_WIDTH-2:0].
  - LSB: data_o = word[DATA_WIDTH-1:1].
- Reset mid-operation: a FULL word is discarded and the pointer returns to 0.
- pop_valid_i changing while not selected has no effect.

Decomposition:
- types_pkg gains:
  - parity_mode_e {EVEN, ODD}
  - parity_pos_e {MSB, LSB}
  - function parity_ok(word, mode), returning 1 when the XOR matches mode.
- Sub-module rr_picker (combinational): inputs req[NUM_SRC] and ptr; outputs found and idx.
  - Reusable by other arbiters in the design.

Test Plan (NUM_SRC=4, DATA_WIDTH=8, EVEN, MSB):
- Hold rst_ni=0 for 3 cycles with pop_valid_i=4'hF and grant_i=1 -> pop_grant_o=0, valid_o=0, all err_cnt=0 throughout.
- Src2 only, data 0x81, grant_i=0 -> pop_grant_o=4'b0100 for one cycle. Next cycle valid_o=1, data_o=7'h01, src_o=2, held stable 5 cycles with pop_grant_o=0.
- Src1 only, data 0x01 (odd) -> pop_grant_o=4'b0010 one cycle, err_cnt[1]=1, valid_o stays 0. Next good 0x03 from src1 -> valid_o=1, data_o=7'h03.
- All four sources valid with good data (0x00, 0x11, 0x22, 0x33), grant_i=1 continuously -> src_o sequence 0,1,2,3,0 on consecutive cycles, valid_o never drops.
- ERR_CNT_WIDTH=2, src0 sends 5 bad words -> err_cnt[0]=3 (saturated). err_clr_i=1 coincident with a 6th bad word -> err_cnt[0]=0.
- FULL state (valid_o=1), then rst_ni=0 for one cycle -> valid_o=0 next cycle. After release with src3 and src0 valid, src0 is served first (pointer=0).
